// File: rtl/ics_tap.sv
// ics_tap: JTAG TAP controller with IR, bypass, boundary-scan, IDCODE and BIST data registers.
// Define USERCODE_EN to build the 32-bit USERCODE data register selected by opcode 8.
`default_nettype none

module ics_tap #(
   parameter logic [31:0] IDCODE_VAL   = 32'h1495_11C3,
`ifdef USERCODE_EN
   parameter logic [31:0] USERCODE_VAL = 32'hA5A5_5A5B,
`endif
   parameter int          BSR_W        = 10
) (
   input  logic TCK,
   input  logic TRST,
   input  logic TMS,
   input  logic TDI,
   output logic TDO
);

   typedef enum logic [3:0] {
      TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
      SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
      UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
      EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
   } tap_state_t;

   localparam logic [3:0] OP_BYPASS   = 4'hF;
   localparam logic [3:0] OP_SAMPLE   = 4'h1;
   localparam logic [3:0] OP_EXTEST   = 4'h2;
   localparam logic [3:0] OP_INTEST   = 4'h3;
   localparam logic [3:0] OP_RUNBIST  = 4'h4;
   localparam logic [3:0] OP_CLAMP    = 4'h5;
   localparam logic [3:0] OP_IDCODE   = 4'h7;
`ifdef USERCODE_EN
   localparam logic [3:0] OP_USERCODE = 4'h8;
`endif
   localparam logic [3:0] OP_HIGHZ    = 4'h9;

   localparam logic [2:0] DR_BYP  = 3'd0;
   localparam logic [2:0] DR_BSR  = 3'd1;
   localparam logic [2:0] DR_ID   = 3'd2;
   localparam logic [2:0] DR_BIST = 3'd4;
`ifdef USERCODE_EN
   localparam logic [2:0] DR_USR  = 3'd3;
`endif

   tap_state_t        state, state_nxt;
   logic [3:0]        ir, ir_sr;
   logic              bypass_sr;
   logic [BSR_W-1:0]  bsr_sr, pin_latch, pin_bus;
   logic [31:0]       id_sr;
`ifdef USERCODE_EN
   logic [31:0]       user_sr;
`endif
   logic [7:0]        bist_sr, bist_cnt;
   logic              pin_oe;
   logic [2:0]        dr_sel;
   logic              dr_lsb;

   // Looped-back pins read 0 while their drivers are disabled.
   assign pin_bus = pin_oe ? pin_latch : '0;

   always_ff @(posedge TCK) begin
      if (TRST) state <= TLR;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         TLR:    state_nxt = TMS ? TLR    : RTI;
         RTI:    state_nxt = TMS ? SEL_DR : RTI;
         SEL_DR: state_nxt = TMS ? SEL_IR : CAP_DR;
         CAP_DR: state_nxt = TMS ? EX1_DR : SH_DR;
         SH_DR:  state_nxt = TMS ? EX1_DR : SH_DR;
         EX1_DR: state_nxt = TMS ? UPD_DR : PAU_DR;
         PAU_DR: state_nxt = TMS ? EX2_DR : PAU_DR;
         EX2_DR: state_nxt = TMS ? UPD_DR : SH_DR;
         UPD_DR: state_nxt = TMS ? SEL_DR : RTI;
         SEL_IR: state_nxt = TMS ? TLR    : CAP_IR;
         CAP_IR: state_nxt = TMS ? EX1_IR : SH_IR;
         SH_IR:  state_nxt = TMS ? EX1_IR : SH_IR;
         EX1_IR: state_nxt = TMS ? UPD_IR : PAU_IR;
         PAU_IR: state_nxt = TMS ? EX2_IR : PAU_IR;
         EX2_IR: state_nxt = TMS ? UPD_IR : SH_IR;
         UPD_IR: state_nxt = TMS ? SEL_DR : RTI;
         default: state_nxt = TLR;
      endcase
   end

   always_comb begin
      dr_sel = DR_BYP;
      case (ir)
         OP_SAMPLE, OP_EXTEST, OP_INTEST: dr_sel = DR_BSR;
         OP_IDCODE:                       dr_sel = DR_ID;
         OP_RUNBIST:                      dr_sel = DR_BIST;
`ifdef USERCODE_EN
         OP_USERCODE:                     dr_sel = DR_USR;
`endif
         OP_BYPASS, OP_CLAMP, OP_HIGHZ:   dr_sel = DR_BYP;
         default:                         dr_sel = DR_BYP;
      endcase
   end

   always_comb begin
      dr_lsb = bypass_sr;
      case (dr_sel)
         DR_BSR:  dr_lsb = bsr_sr[0];
         DR_ID:   dr_lsb = id_sr[0];
         DR_BIST: dr_lsb = bist_sr[0];
`ifdef USERCODE_EN
         DR_USR:  dr_lsb = user_sr[0];
`endif
         default: dr_lsb = bypass_sr;
      endcase
   end

   always_ff @(posedge TCK) begin
      if (TRST) begin
         ir        <= OP_IDCODE;
         ir_sr     <= '0;
         bypass_sr <= 1'b0;
         bsr_sr    <= '0;
         id_sr     <= '0;
`ifdef USERCODE_EN
         user_sr   <= '0;
`endif
         bist_sr   <= '0;
         pin_latch <= '0;
         pin_oe    <= 1'b1;
         bist_cnt  <= '0;
      end else begin
         pin_oe <= (ir != OP_HIGHZ);
         case (state)
            TLR:    ir    <= OP_IDCODE;
            CAP_IR: ir_sr <= 4'b0001;
            SH_IR:  ir_sr <= {TDI, ir_sr[3:1]};
            UPD_IR: begin
               ir       <= ir_sr;
               bist_cnt <= '0;
            end
            RTI: begin
               if (ir == OP_RUNBIST && bist_cnt != 8'hFF)
                  bist_cnt <= bist_cnt + 8'd1;
            end
            CAP_DR: begin
               case (dr_sel)
                  DR_BSR:  bsr_sr    <= pin_bus;
                  DR_ID:   id_sr     <= IDCODE_VAL;
                  DR_BIST: bist_sr   <= bist_cnt;
`ifdef USERCODE_EN
                  DR_USR:  user_sr   <= USERCODE_VAL;
`endif
                  default: bypass_sr <= 1'b0;
               endcase
            end
            SH_DR: begin
               case (dr_sel)
                  DR_BSR:  bsr_sr    <= {TDI, bsr_sr[BSR_W-1:1]};
                  DR_ID:   id_sr     <= {TDI, id_sr[31:1]};
                  DR_BIST: bist_sr   <= {TDI, bist_sr[7:1]};
`ifdef USERCODE_EN
                  DR_USR:  user_sr   <= {TDI, user_sr[31:1]};
`endif
                  default: bypass_sr <= TDI;
               endcase
            end
            UPD_DR: begin
               if (dr_sel == DR_BSR && (ir == OP_EXTEST || ir == OP_INTEST))
                  pin_latch <= bsr_sr;
            end
            default: ;
         endcase
      end
   end

   always_ff @(negedge TCK) begin
      if (state == SH_IR)      TDO <= ir_sr[0];
      else if (state == SH_DR) TDO <= dr_lsb;
      else                     TDO <= 1'b0;
   end

endmodule

`default_nettype wire

// File: tb/tb_ics_tap.sv
// tb_ics_tap: random and directed scans of ics_tap against a transaction-level model.
`default_nettype none

module tb_ics_tap;

   localparam logic [31:0] IDCODE_VAL   = 32'h1495_11C3;
   localparam logic [31:0] USERCODE_VAL = 32'hA5A5_5A5B;

   logic TCK = 1'b0;
   logic TRST = 1'b1;
   logic TMS = 1'b1;
   logic TDI = 1'b0;
   logic TDO;

   int n_chk = 0;
   int n_err = 0;

   // Model state: current instruction, looped-back pin latch, BIST counter.
   logic [3:0] ir_m;
   logic [9:0] pin_m;
   logic [7:0] bist_m;

   ics_tap dut (
      .TCK  (TCK),
      .TRST (TRST),
      .TMS  (TMS),
      .TDI  (TDI),
      .TDO  (TDO)
   );

   always #5 TCK = ~TCK;

   initial begin
      #5_000_000;
      n_chk++;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      @(negedge TCK);
      #1;
   endtask

   function automatic int dr_width(input logic [3:0] op);
      case (op)
         4'h1, 4'h2, 4'h3: return 10;
         4'h7:             return 32;
         4'h4:             return 8;
`ifdef USERCODE_EN
         4'h8:             return 32;
`endif
         default:          return 1;
      endcase
   endfunction

   function automatic logic [31:0] dr_capture(input logic [3:0] op);
      case (op)
         4'h1, 4'h2, 4'h3: return {22'b0, pin_m};
         4'h7:             return IDCODE_VAL;
         4'h4:             return {24'b0, bist_m};
`ifdef USERCODE_EN
         4'h8:             return USERCODE_VAL;
`endif
         default:          return 32'b0;
      endcase
   endfunction

   function automatic logic [63:0] low_mask(input int n);
      return (64'd1 << n) - 64'd1;
   endfunction

   // One rising edge spent in Run-Test/Idle.
   task automatic rti_edge_model();
      if (ir_m == 4'h4 && bist_m != 8'hFF) bist_m = bist_m + 8'd1;
   endtask

   task automatic model_reset();
      ir_m   = 4'h7;
      pin_m  = '0;
      bist_m = '0;
   endtask

   task automatic do_reset();
      TRST = 1'b1;
      tick(1'b0, 1'b0);
      TRST = 1'b0;
      model_reset();
      check("reset_state", 64'(dut.state), 64'hF);
      check("reset_tdo", 64'(TDO), 64'h0);
   endtask

   task automatic run_idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1'b0, 1'b0);
         rti_edge_model();
      end
   endtask

   // Entered Shift state already; leaves through Exit1/Update back to RTI.
   task automatic scan_bits(input int n, input logic [63:0] data, output logic [63:0] out);
      out = '0;
      for (int i = 0; i < n; i++) begin
         out[i] = TDO;
         tick(i == n - 1, data[i]);
      end
      check("tdo_exit", 64'(TDO), 64'h0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   task automatic do_ir(input logic [3:0] op, input string tag);
      logic [63:0] out;
      rti_edge_model();
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      scan_bits(4, {60'b0, op}, out);
      check({tag, "_ircap"}, {60'b0, out[3:0]}, 64'h1);
      ir_m   = op;
      bist_m = '0;
   endtask

   task automatic do_dr(input int n, input logic [63:0] data, input string tag);
      logic [63:0]  out;
      logic [127:0] stream;
      int           w;
      rti_edge_model();
      w      = dr_width(ir_m);
      stream = ({96'b0, dr_capture(ir_m)} & ((128'd1 << w) - 128'd1)) | ({64'b0, data} << w);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      scan_bits(n, data, out);
      check(tag, out & low_mask(n), stream[63:0] & low_mask(n));
      if (ir_m == 4'h2 || ir_m == 4'h3) begin
         stream = stream >> n;
         pin_m  = stream[9:0];
      end
   endtask

   initial begin
      logic [3:0]  ops [10];
      logic [3:0]  op;
      logic [63:0] data;
      int          n;
      ops = '{4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'h0};
      model_reset();

      tick(1'b1, 1'b0);
      do_reset();

      // Any walk followed by five TMS=1 clocks lands in Test-Logic-Reset.
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < int'($urandom_range(3, 25)); i++)
            tick(1'($urandom), 1'b0);
         for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
         check("five_tms_tlr", 64'(dut.state), 64'hF);
      end
      do_reset();
      tick(1'b0, 1'b0);

      do_dr(32, 64'h0, "idcode_after_reset");

      do_ir(4'hF, "bypass");
      do_dr(2, 64'h0, "bypass_00");
      do_dr(8, 64'h81, "bypass_81");

      do_ir(4'h2, "extest");
      do_dr(10, 64'h26F, "extest_load");
      do_dr(10, 64'h0, "extest_readback");

      do_ir(4'h1, "sample");
      do_dr(10, 64'h294, "sample_shift");
      do_dr(10, 64'h0, "sample_readback");

      do_ir(4'h4, "runbist");
      run_idle(2);
      do_dr(8, 64'h0, "bist_3");
      run_idle(300);
      do_dr(8, 64'h0, "bist_sat");

      do_ir(4'h9, "highz");
      do_dr(3, 64'h5, "highz_dr");
      check("pin_oe_highz", 64'(dut.pin_oe), 64'h0);
      do_ir(4'hF, "bypass2");
      do_dr(3, 64'h2, "bypass2_dr");
      check("pin_oe_bypass", 64'(dut.pin_oe), 64'h1);

      // Reset in the middle of an EXTEST shift must abort without an update.
      do_ir(4'h2, "extest_abort");
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
      do_reset();
      tick(1'b0, 1'b0);
      do_ir(4'h2, "extest_after_abort");
      do_dr(10, 64'h0, "pins_after_abort");

      for (int it = 0; it < 40; it++) begin
         op = ops[$urandom_range(0, 9)];
         if ($urandom_range(0, 5) == 0) op = 4'($urandom);
         do_ir(op, "rand");
         if (op == 4'h4) run_idle($urandom_range(0, 6));
         n    = dr_width(op) + $urandom_range(0, 8) - 3;
         if (n < 1) n = 1;
         data = {$urandom, $urandom};
         do_dr(n, data, "rand_dr");
         check("rand_pin_oe", 64'(dut.pin_oe), 64'(ir_m != 4'h9));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
